id_reveal: RTL and testbench

ID_REVEAL -- requirements
Module: id_reveal

---
 rtl/id_reveal.sv | 102 ++++++++++
 tb/tb_id_reveal.sv | 120 ++++++++++++
 2 files changed

// File: rtl/id_reveal.sv
// Eight-digit multiplexed 7-segment scanner that reveals a fixed hex ID
// one digit at a time, left to right, then holds the full ID on display.
module id_reveal #(
  parameter int          SCAN_DIV      = 50000,
  parameter int          REVEAL_FRAMES = 250,
  parameter logic [31:0] ID_DIGITS     = 32'h20220809
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] led,
  output logic [2:0] del
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;

  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRM_MAX = FW'(REVEAL_FRAMES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    del_q, del_d;
  logic [FW-1:0] frm_q, frm_d;
  logic [3:0]    rev_q, rev_d;

  logic          tick;
  logic          frame_end;
  logic [3:0]    nib;
  logic [6:0]    seg;
  logic [4:0]    sh;

  // Prescaler, digit index, frame counter and reveal count next-state.
  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    del_d     = del_q;
    frm_d     = frm_q;
    rev_d     = rev_q;
    tick      = (cnt_q == CNT_MAX);
    frame_end = 1'b0;
    if (tick) begin
      cnt_d = '0;
      del_d = del_q + 3'd1;
      if (del_q == 3'd7) begin
        if (frm_q == FRM_MAX) begin
          frm_d     = '0;
          frame_end = 1'b1;
        end else begin
          frm_d = frm_q + 1'b1;
        end
      end
    end
    if (frame_end && (rev_q != 4'd8)) begin
      rev_d = rev_q + 4'd1;
    end
  end

  // State registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      del_q <= '0;
      frm_q <= '0;
      rev_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      del_q <= del_d;
      frm_q <= frm_d;
      rev_q <= rev_d;
    end
  end

  // Segment decode of the current digit; hidden digits stay dark.
  always_comb begin
    sh  = {~del_q, 2'b00};
    nib = ID_DIGITS[sh +: 4];
    seg = 7'h00;
    unique case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
    endcase
    led = 8'h00;
    if ({1'b0, del_q} < rev_q) begin
      led = {1'b0, seg};
    end
  end

  assign del = del_q;

endmodule

// File: tb/tb_id_reveal.sv
// Scoreboard bench for id_reveal: a cycle model pushes the expected
// del/led pair per edge, popped and compared just after the edge.
module tb_id_reveal;

  localparam int SD = 4;
  localparam int RF = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] led;
  logic [2:0] del;

  id_reveal #(
    .SCAN_DIV(SD),
    .REVEAL_FRAMES(RF),
    .ID_DIGITS(32'h20220809)
  ) dut (
    .clk(clk),
    .rst(rst),
    .led(led),
    .del(del)
  );

  always #5 clk = ~clk;

  int errs  = 0;
  int total = 0;
  int n     = 0;

  logic [10:0] sb[$];
  logic [31:0] id = 32'h20220809;
  logic [7:0]  seg_tbl[16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] model(input int k);
    int d;
    int r;
    logic [3:0] nib;
    logic [7:0] l;
    d = (k / SD) % 8;
    r = k / (SD * 8 * RF);
    if (r > 8) r = 8;
    nib = id[(7 - d) * 4 +: 4];
    l = (d < r) ? seg_tbl[nib] : 8'h00;
    return {d[2:0], l};
  endfunction

  task automatic step(input int cnt);
    logic [10:0] e;
    repeat (cnt) begin
      @(posedge clk);
      n++;
      sb.push_back(model(n));
      #1;
      if (sb.size() == 0) begin
        check_eq("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("del", {29'd0, del}, {29'd0, e[10:8]});
        check_eq("led", {24'd0, led}, {24'd0, e[7:0]});
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_eq("rst_del", {29'd0, del}, 32'd0);
    check_eq("rst_led", {24'd0, led}, 32'd0);

    @(negedge clk);
    rst = 1'b0;
    n   = 0;

    step(4);
    check_eq("del_at4", {29'd0, del}, 32'd1);
    step(24);
    check_eq("del_at28", {29'd0, del}, 32'd7);
    step(4);
    check_eq("del_at32", {29'd0, del}, 32'd0);
    step(32);
    check_eq("rev1_d0", {24'd0, led}, 32'h5B);
    step(448);
    check_eq("rev8_d0", {24'd0, led}, 32'h5B);
    step(28);
    check_eq("rev8_d7", {24'd0, led}, 32'h6F);
    step(2000);

    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_del", {29'd0, del}, 32'd0);
    check_eq("mid_rst_led", {24'd0, led}, 32'd0);
    #1 rst = 1'b0;
    n = 0;
    sb.delete();

    step(4);
    check_eq("re_del_at4", {29'd0, del}, 32'd1);
    step(60);
    check_eq("re_rev1_d0", {24'd0, led}, 32'h5B);
    step(220);

    $display("Result: errors=%0d of %0d checks", errs, total);
    $finish;
  end

endmodule
